// File: rtl/apu_dispatcher_pkg.sv
// Shared types, opcode constants and the scalar-writeback decode for the APU dispatcher.
`default_nettype none

package apu_dispatcher_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    WB       = 2'd3
  } apu_disp_state_t;

  localparam logic [6:0] V_MAJOR_OP_V       = 7'b1010111;
  localparam logic [2:0] V_OPCFG            = 3'b111;
  localparam logic [2:0] V_OPMVV            = 3'b010;
  localparam logic [5:0] V_FUNCT6_VWXUNARY0 = 6'b010000;

  // True for vsetvli/vsetvl and vmv.x.s with a non-zero destination register.
  function automatic logic apu_writes_scalar(
    input logic [6:0] opcode,
    input logic [2:0] funct3,
    input logic [5:0] funct6,
    input logic [4:0] rd
  );
    logic w_is_cfg;
    logic w_is_vmvxs;
    w_is_cfg   = (funct3 == V_OPCFG);
    w_is_vmvxs = (funct3 == V_OPMVV) && (funct6 == V_FUNCT6_VWXUNARY0);
    return (opcode == V_MAJOR_OP_V) && (w_is_cfg || w_is_vmvxs) && (rd != 5'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apu_dispatcher.sv
// Single-outstanding APU request/grant/rvalid initiator with optional scalar writeback.
// Optional macro APU_TIMEOUT_EN adds a grant-to-rvalid watchdog with sticky timeout_o.
`default_nettype none

module apu_dispatcher
  import apu_dispatcher_pkg::*;
#(
  parameter logic [5:0] APU_OP_DEFAULT = 6'd0,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [31:0]      issue_instr_i,
  input  logic [31:0]      issue_rs1_i,
  input  logic [31:0]      issue_rs2_i,
  input  logic [14:0]      issue_flags_i,
  output logic             apu_req_o,
  input  logic             apu_gnt_i,
  output logic [2:0][31:0] apu_operands_o,
  output logic [5:0]       apu_op_o,
  output logic [14:0]      apu_flags_o,
  input  logic             apu_rvalid_i,
  input  logic [31:0]      apu_result_i,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output logic [31:0]      wb_data_o,
  output logic             busy_o,
  output logic             timeout_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("apu_dispatcher: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  apu_disp_state_t r_state;
  logic [31:0]     r_instr;
  logic [31:0]     r_rs1;
  logic [31:0]     r_rs2;
  logic [14:0]     r_flags;
  logic            r_writes_rd;
  logic            r_req;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [31:0]     r_wb_data;

`ifdef APU_TIMEOUT_EN
  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo_cnt;
  logic        r_timeout;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= IDLE;
      r_instr     <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_flags     <= '0;
      r_writes_rd <= 1'b0;
      r_req       <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
`ifdef APU_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (issue_valid_i) begin
            r_instr     <= issue_instr_i;
            r_rs1       <= issue_rs1_i;
            r_rs2       <= issue_rs2_i;
            r_flags     <= issue_flags_i;
            r_writes_rd <= apu_writes_scalar(issue_instr_i[6:0], issue_instr_i[14:12],
                                             issue_instr_i[31:26], issue_instr_i[11:7]);
            r_req       <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          // rvalid cannot legally arrive before the grant, so it is not looked at here.
          if (apu_gnt_i) begin
            r_req   <= 1'b0;
            r_state <= WAIT_RSP;
`ifdef APU_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        WAIT_RSP: begin
          if (apu_rvalid_i) begin
            if (r_writes_rd) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_instr[11:7];
              r_wb_data  <= apu_result_i;
              r_state    <= WB;
            end else begin
              r_state <= IDLE;
            end
          end
`ifdef APU_TIMEOUT_EN
          else if (r_tmo_cnt == c_tmo_last) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
`endif
        end
        WB: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign issue_ready_o  = (r_state == IDLE);
  assign busy_o         = (r_state != IDLE);
  assign apu_req_o      = r_req;
  assign apu_operands_o = {r_rs2, r_rs1, r_instr};
  assign apu_op_o       = APU_OP_DEFAULT;
  assign apu_flags_o    = r_flags;
  assign wb_valid_o     = r_wb_valid;
  assign wb_rd_o        = r_wb_rd;
  assign wb_data_o      = r_wb_data;

`ifdef APU_TIMEOUT_EN
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_apu_dispatcher.sv
// Scoreboard-based bench for apu_dispatcher: expected writebacks queued at rvalid, popped at wb_valid_o.
`default_nettype none

module tb_apu_dispatcher;

  logic             clk;
  logic             n_reset;
  logic             issue_valid_i;
  logic             issue_ready_o;
  logic [31:0]      issue_instr_i;
  logic [31:0]      issue_rs1_i;
  logic [31:0]      issue_rs2_i;
  logic [14:0]      issue_flags_i;
  logic             apu_req_o;
  logic             apu_gnt_i;
  logic [2:0][31:0] apu_operands_o;
  logic [5:0]       apu_op_o;
  logic [14:0]      apu_flags_o;
  logic             apu_rvalid_i;
  logic [31:0]      apu_result_i;
  logic             wb_valid_o;
  logic [4:0]       wb_rd_o;
  logic [31:0]      wb_data_o;
  logic             busy_o;
  logic             timeout_o;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [36:0] sb[$];

  localparam logic [31:0] VADD = 32'h022180D7;

  apu_dispatcher #(
    .APU_OP_DEFAULT(6'd0),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_instr_i  (issue_instr_i),
    .issue_rs1_i    (issue_rs1_i),
    .issue_rs2_i    (issue_rs2_i),
    .issue_flags_i  (issue_flags_i),
    .apu_req_o      (apu_req_o),
    .apu_gnt_i      (apu_gnt_i),
    .apu_operands_o (apu_operands_o),
    .apu_op_o       (apu_op_o),
    .apu_flags_o    (apu_flags_o),
    .apu_rvalid_i   (apu_rvalid_i),
    .apu_result_i   (apu_result_i),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_o        (wb_rd_o),
    .wb_data_o      (wb_data_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Writeback scoreboard and handshake counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (n_reset && apu_req_o && apu_gnt_i) hs_count++;
    if (n_reset && wb_valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", wb_rd_o, wb_data_o);
      end else begin
        logic [36:0] exp;
        exp = sb.pop_front();
        if ({wb_rd_o, wb_data_o} !== exp) begin
          errors++;
          $display("FAIL wb_payload: got rd=%0d data=%h, required rd=%0d data=%h",
                   wb_rd_o, wb_data_o, exp[36:32], exp[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] f_vsetvli(input logic [4:0] rd);
    return 32'h00057057 | {20'd0, rd, 7'd0};
  endfunction

  function automatic logic [31:0] f_vmvxs(input logic [4:0] rd);
    return 32'h42402057 | {20'd0, rd, 7'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for one cycle and checks the 1-cycle issue-to-request latency.
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [14:0] flags);
    checks++;
    if (issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready_idle: got %b, required 1", issue_ready_o);
    end
    issue_valid_i = 1'b1;
    issue_instr_i = instr;
    issue_rs1_i   = rs1;
    issue_rs2_i   = rs2;
    issue_flags_i = flags;
    step();
    issue_valid_i = 1'b0;
    issue_instr_i = '0;
    issue_rs1_i   = '0;
    issue_rs2_i   = '0;
    issue_flags_i = '0;
    checks++;
    if (apu_req_o !== 1'b1 || issue_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_accept: got req=%b ready=%b busy=%b, required req=1 ready=0 busy=1",
               apu_req_o, issue_ready_o, busy_o);
    end
    checks++;
    if (apu_operands_o[0] !== instr || apu_operands_o[1] !== rs1 || apu_operands_o[2] !== rs2 ||
        apu_flags_o !== flags || apu_op_o !== 6'd0) begin
      errors++;
      $display("FAIL issue_payload: got ops=%h/%h/%h flags=%h op=%h, required %h/%h/%h flags=%h op=0",
               apu_operands_o[0], apu_operands_o[1], apu_operands_o[2], apu_flags_o, apu_op_o,
               instr, rs1, rs2, flags);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (2) step();
    checks++;
    if (apu_req_o !== 1'b0 || wb_valid_o !== 1'b0 || wb_rd_o !== 5'd0 || wb_data_o !== 32'd0 ||
        timeout_o !== 1'b0 || busy_o !== 1'b0 || apu_operands_o !== '0 || apu_flags_o !== 15'd0) begin
      errors++;
      $display("FAIL reset_values: got req=%b wbv=%b rd=%0d data=%h tmo=%b busy=%b ops=%h flags=%h, required all 0",
               apu_req_o, wb_valid_o, wb_rd_o, wb_data_o, timeout_o, busy_o, apu_operands_o, apu_flags_o);
    end
    n_reset = 1'b1;
    step();
    checks++;
    if (issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", issue_ready_o);
    end
  endtask

  task automatic test_vsetvli();
    apu_gnt_i = 1'b1;
    issue(f_vsetvli(5'd5), 32'd7, 32'd0, 15'h0101);
    step();
    apu_gnt_i = 1'b0;
    checks++;
    if (apu_req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL vsetvli_granted: got req=%b busy=%b, required req=0 busy=1", apu_req_o, busy_o);
    end
    step();
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'd7;
    sb.push_back({5'd5, 32'd7});
    step();
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    checks++;
    if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd5 || wb_data_o !== 32'd7) begin
      errors++;
      $display("FAIL vsetvli_wb: got v=%b rd=%0d data=%h, required v=1 rd=5 data=7",
               wb_valid_o, wb_rd_o, wb_data_o);
    end
    step();
    checks++;
    if (busy_o !== 1'b0 || wb_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL vsetvli_done: got busy=%b wbv=%b ready=%b, required 0 0 1",
               busy_o, wb_valid_o, issue_ready_o);
    end
  endtask

  task automatic test_no_wb();
    apu_gnt_i = 1'b1;
    issue(VADD, 32'h1, 32'h2, 15'h0);
    step();
    apu_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (issue_ready_o !== 1'b0 || busy_o !== 1'b1 || apu_req_o !== 1'b0) begin
        errors++;
        $display("FAIL vadd_wait[%0d]: got ready=%b busy=%b req=%b, required 0 1 0",
                 i, issue_ready_o, busy_o, apu_req_o);
      end
      step();
    end
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'hBAD0BAD0;
    step();
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    checks++;
    if (issue_ready_o !== 1'b1 || busy_o !== 1'b0 || wb_valid_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL vadd_done: got ready=%b busy=%b wbv=%b tmo=%b, required 1 0 0 0",
               issue_ready_o, busy_o, wb_valid_o, timeout_o);
    end
  endtask

  task automatic test_gnt_stall();
    int hs0;
    hs0 = hs_count;
    apu_gnt_i = 1'b0;
    issue(f_vmvxs(5'd7), 32'hAAAA5555, 32'h00001234, 15'h5A5A);
    for (int i = 0; i < 3; i++) begin
      apu_rvalid_i = (i == 1);
      apu_result_i = (i == 1) ? 32'hFFFF0000 : 32'd0;
      step();
      checks++;
      if (apu_req_o !== 1'b1 || apu_operands_o[0] !== f_vmvxs(5'd7) ||
          apu_operands_o[1] !== 32'hAAAA5555 || apu_operands_o[2] !== 32'h00001234 ||
          apu_flags_o !== 15'h5A5A) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got req=%b ops=%h flags=%h, required stable request",
                 i, apu_req_o, apu_operands_o, apu_flags_o);
      end
    end
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    apu_gnt_i = 1'b1;
    step();
    apu_gnt_i = 1'b0;
    checks++;
    if (apu_req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_grant: got req=%b busy=%b, required req=0 busy=1", apu_req_o, busy_o);
    end
    step();
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'hCAFEF00D;
    sb.push_back({5'd7, 32'hCAFEF00D});
    step();
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    step();
    checks++;
    if (hs_count - hs0 !== 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_handshakes: got hs=%0d busy=%b, required hs=1 busy=0", hs_count - hs0, busy_o);
    end
  endtask

  task automatic test_rd0();
    apu_gnt_i = 1'b1;
    issue(f_vmvxs(5'd0), 32'd0, 32'd0, 15'h7FFF);
    step();
    apu_gnt_i = 1'b0;
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'h0000DEAD;
    step();
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    checks++;
    if (busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rd0_no_wb: got busy=%b wbv=%b, required 0 0", busy_o, wb_valid_o);
    end
    step();
    checks++;
    if (wb_valid_o !== 1'b0 || wb_data_o === 32'h0000DEAD) begin
      errors++;
      $display("FAIL rd0_quiet: got wbv=%b data=%h, required wbv=0 data!=dead", wb_valid_o, wb_data_o);
    end
  endtask

  task automatic test_back_to_back();
    apu_gnt_i = 1'b1;
    issue(f_vsetvli(5'd6), 32'd16, 32'd0, 15'h0001);
    step();
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'h11;
    sb.push_back({5'd6, 32'h11});
    step();
    apu_rvalid_i = 1'b0;
    checks++;
    if (issue_ready_o !== 1'b0 || wb_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wb_cycle: got ready=%b wbv=%b, required 0 1", issue_ready_o, wb_valid_o);
    end
    step();
    issue(VADD, 32'd3, 32'd4, 15'h0002);
    step();
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'h99;
    step();
    apu_rvalid_i = 1'b0;
    checks++;
    if (issue_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_nowb_period: got ready=%b wbv=%b, required 1 0", issue_ready_o, wb_valid_o);
    end
    issue(f_vsetvli(5'd9), 32'd32, 32'd0, 15'h0003);
    step();
    apu_gnt_i = 1'b0;
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'h22;
    sb.push_back({5'd9, 32'h22});
    step();
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    step();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_async_reset();
    apu_gnt_i = 1'b1;
    issue(f_vsetvli(5'd5), 32'd8, 32'd0, 15'h1234);
    step();
    apu_gnt_i = 1'b0;
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || apu_req_o !== 1'b0 || issue_ready_o !== 1'b1 ||
        apu_operands_o !== '0 || apu_flags_o !== 15'd0 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b req=%b ready=%b ops=%h flags=%h wbv=%b, required reset values",
               busy_o, apu_req_o, issue_ready_o, apu_operands_o, apu_flags_o, wb_valid_o);
    end
    step();
    n_reset = 1'b1;
    step();
    checks++;
    if (busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_release: got busy=%b wbv=%b, required 0 0", busy_o, wb_valid_o);
    end
    apu_gnt_i = 1'b1;
    issue(f_vsetvli(5'd3), 32'd4, 32'd0, 15'h0040);
    step();
    apu_gnt_i = 1'b0;
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'd4;
    sb.push_back({5'd3, 32'd4});
    step();
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    step();
  endtask

`ifdef APU_TIMEOUT_EN
  task automatic test_timeout();
    apu_gnt_i = 1'b1;
    issue(VADD, 32'd0, 32'd0, 15'd0);
    step();
    apu_gnt_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early[%0d]: got tmo=%b busy=%b, required 0 1", i, timeout_o, busy_o);
      end
    end
    step();
    checks++;
    if (timeout_o !== 1'b1 || busy_o !== 1'b0 || issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: got tmo=%b busy=%b ready=%b, required 1 0 1",
               timeout_o, busy_o, issue_ready_o);
    end
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'h5;
    step();
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    step();
    checks++;
    if (timeout_o !== 1'b1 || busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late_rvalid: got tmo=%b busy=%b wbv=%b, required 1 0 0",
               timeout_o, busy_o, wb_valid_o);
    end
  endtask
`endif

  initial begin
    n_reset       = 1'b0;
    issue_valid_i = 1'b0;
    issue_instr_i = '0;
    issue_rs1_i   = '0;
    issue_rs2_i   = '0;
    issue_flags_i = '0;
    apu_gnt_i     = 1'b0;
    apu_rvalid_i  = 1'b0;
    apu_result_i  = '0;

    test_reset();
    test_vsetvli();
    test_no_wb();
    test_gnt_stall();
    test_rd0();
    test_back_to_back();
    test_async_reset();
`ifdef APU_TIMEOUT_EN
    test_timeout();
`endif
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wb_missing: got %0d writebacks outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
